led_scan_initiator: RTL and testbench

- Drives the scan address `row_now`/`col_now` consumed by the combinational area-decode blocks.
- Samples their `judge1..3` hit flags and converts them to per-pixel brightness.
- Serialises one bit-plane per row to the LED panel shift chain using binary-code modulation (BCM), with latch/OE control.
- Sits between the frame controller (`frame_start`/`frame_done`) and the panel I/O pins; it is the master side of the `row_now`/`col_now` -> `judge*` interface.

---
 rtl/led_scan_initiator.sv | 148 ++++++++++++++
 tb/tb_led_scan_initiator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_initiator.sv
`timescale 1ns/1ps
// Scans row/col addresses into the area decoders, maps judge hits to brightness and shifts BCM bit-planes to the LED panel.
// Latency: one plane = SETUP + 2*COLS shift + LATCH + UNIT<<plane display + NEXT cycles; no backpressure, frame_start is ignored while busy.
module led_scan_initiator #(
    parameter int ROWS   = 54,
    parameter int COLS   = 64,
    parameter int PLANES = 4,
    parameter int UNIT   = 8,
    parameter logic [PLANES-1:0] LVL1 = 4'd15,
    parameter logic [PLANES-1:0] LVL2 = 4'd9,
    parameter logic [PLANES-1:0] LVL3 = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       judge1,
    input  logic       judge2,
    input  logic       judge3,
    output logic [6:0] row_now,
    output logic [6:0] col_now,
    output logic       led_sdo,
    output logic       led_sclk,
    output logic       led_lat,
    output logic       led_oe_n,
    output logic [6:0] row_sel,
    output logic       busy,
    output logic       frame_done
);

    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DW = PLANES - 1 + $clog2(UNIT) + 1;
    localparam logic [6:0]    LAST_ROW   = 7'(ROWS - 1);
    localparam logic [6:0]    LAST_COL   = 7'(COLS - 1);
    localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);
    localparam logic [DW-1:0] UNIT_W     = DW'(UNIT);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DISPLAY,
        NEXT
    } state_t;

    state_t          state;
    logic [6:0]      row_idx;
    logic [PW-1:0]   plane;
    logic [DW-1:0]   disp_cnt;
    logic [PLANES-1:0] lvl;

    // judge1 has the highest priority when several decoders hit the same pixel
    always_comb begin
        lvl = '0;
        if (judge1)      lvl = LVL1;
        else if (judge2) lvl = LVL2;
        else if (judge3) lvl = LVL3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_idx    <= '0;
            plane      <= '0;
            disp_cnt   <= '0;
            row_now    <= '0;
            col_now    <= '0;
            row_sel    <= '0;
            led_sdo    <= 1'b0;
            led_sclk   <= 1'b0;
            led_lat    <= 1'b0;
            led_oe_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        busy    <= 1'b1;
                        row_idx <= '0;
                        plane   <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    col_now <= '0;
                    row_now <= row_idx;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    led_sclk <= 1'b0;
                    led_sdo  <= lvl[plane];
                    state    <= SHIFT_HI;
                end
                SHIFT_HI: begin
                    // data was set one cycle earlier, so the rising edge lands mid-bit
                    led_sclk <= 1'b1;
                    if (col_now == LAST_COL) begin
                        state <= LATCH;
                    end else begin
                        col_now <= col_now + 7'd1;
                        state   <= SHIFT_LO;
                    end
                end
                LATCH: begin
                    led_sclk <= 1'b0;
                    led_oe_n <= 1'b1;
                    led_lat  <= 1'b1;
                    row_sel  <= row_idx;
                    disp_cnt <= (UNIT_W << plane) - DW'(1);
                    state    <= DISPLAY;
                end
                DISPLAY: begin
                    // lat is visible for the first display cycle; oe_n drops behind it and stays
                    // low through NEXT, giving exactly UNIT<<plane enabled cycles
                    led_lat  <= 1'b0;
                    led_oe_n <= 1'b0;
                    if (disp_cnt == '0) begin
                        state <= NEXT;
                    end else begin
                        disp_cnt <= disp_cnt - DW'(1);
                    end
                end
                NEXT: begin
                    led_oe_n <= 1'b1;
                    if (plane != LAST_PLANE) begin
                        plane <= plane + PW'(1);
                        state <= SETUP;
                    end else begin
                        plane <= '0;
                        if (row_idx != LAST_ROW) begin
                            row_idx <= row_idx + 7'd1;
                            state   <= SETUP;
                        end else begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_initiator.sv
`timescale 1ns/1ps
// Bench for led_scan_initiator: decoder stub backed by hit tables, scoreboard of expected bit-planes per latch.
module tb_led_scan_initiator;

    localparam int ROWS    = 54;
    localparam int COLS    = 64;
    localparam int PLANES  = 4;
    localparam int UNIT    = 8;
    localparam int PER_ROW = PLANES * (1 + 2 * COLS + 1 + 1) + UNIT * ((1 << PLANES) - 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       judge1, judge2, judge3;
    logic [6:0] row_now, col_now, row_sel;
    logic       led_sdo, led_sclk, led_lat, led_oe_n, busy, frame_done;

    always #5 clk = ~clk;

    led_scan_initiator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .judge1     (judge1),
        .judge2     (judge2),
        .judge3     (judge3),
        .row_now    (row_now),
        .col_now    (col_now),
        .led_sdo    (led_sdo),
        .led_sclk   (led_sclk),
        .led_lat    (led_lat),
        .led_oe_n   (led_oe_n),
        .row_sel    (row_sel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Decoder stub: hit tables indexed by the scan address
    bit [127:0] j1 [128];
    bit [127:0] j2 [128];
    bit [127:0] j3 [128];
    assign judge1 = j1[row_now][col_now];
    assign judge2 = j2[row_now][col_now];
    assign judge3 = j3[row_now][col_now];

    typedef struct {
        int              row;
        int              plane;
        logic [COLS-1:0] bits;
        int              dur;
    } exp_t;

    exp_t sb [$];
    logic [COLS-1:0] captured [ROWS][PLANES];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    int nlatch   = 0;
    int viol     = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [3:0] ref_lvl(input int r, input int c);
        if (j1[r][c]) return 4'd15;
        if (j2[r][c]) return 4'd9;
        if (j3[r][c]) return 4'd3;
        return 4'd0;
    endfunction

    task automatic load_expect();
        exp_t e;
        logic [3:0] l;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < PLANES; p++) begin
                e.row = r;
                e.plane = p;
                e.dur = UNIT << p;
                e.bits = '0;
                for (int c = 0; c < COLS; c++) begin
                    l = ref_lvl(r, c);
                    e.bits[c] = l[p];
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic clear_tables();
        for (int r = 0; r < 128; r++) begin
            j1[r] = '0;
            j2[r] = '0;
            j3[r] = '0;
        end
    endtask

    task automatic random_tables(input int rmax);
        for (int r = 0; r < rmax; r++) begin
            for (int c = 0; c < COLS; c++) begin
                j1[r][c] = ($urandom_range(0, 5) == 0);
                j2[r][c] = ($urandom_range(0, 3) == 0);
                j3[r][c] = ($urandom_range(0, 2) == 0);
            end
        end
    endtask

    // Monitor: collects shifted bits, pops the scoreboard on every latch, watches panel protocol
    int              colcnt;
    logic [COLS-1:0] word;
    exp_t            cur;
    int              low_run;
    logic            p_sclk, p_sdo, p_oe_n;
    logic [6:0]      p_row_sel;

    always @(posedge clk) begin
        #1;
        if (!mon_en) begin
            colcnt  = 0;
            word    = '0;
            low_run = 0;
            cur.dur = 0;
        end else begin
            if (led_sclk && !p_sclk) begin
                if (led_sdo !== p_sdo) viol++;
                if (!led_oe_n) viol++;
                if (colcnt < COLS) word[colcnt] = led_sdo;
                colcnt++;
            end
            if (led_sclk && p_sclk && led_sdo !== p_sdo) viol++;
            if (row_sel !== p_row_sel && !led_lat) viol++;
            if (led_lat) begin
                if (!led_oe_n) viol++;
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    cur = sb.pop_front();
                    check("sclk_per_latch", 64'(colcnt), 64'(COLS));
                    check("row_bits", 64'(word), 64'(cur.bits));
                    check("row_sel", 64'(row_sel), 64'(cur.row));
                    captured[cur.row][cur.plane] = word;
                    nlatch++;
                end
                colcnt = 0;
                word   = '0;
            end
            if (!led_oe_n) begin
                low_run++;
            end else if (!p_oe_n) begin
                check("oe_low_cycles", 64'(low_run), 64'(cur.dur));
                low_run = 0;
            end
        end
        p_sclk    = led_sclk;
        p_sdo     = led_sdo;
        p_oe_n    = led_oe_n;
        p_row_sel = row_sel;
    end

    function automatic logic [15:0] out_vec();
        return {row_now, col_now, led_sdo, led_sclk};
    endfunction

    function automatic logic [12:0] ctl_vec();
        return {row_sel, led_lat, led_oe_n, busy, frame_done, 2'b00};
    endfunction

    task automatic run_frame(input int pulse_at);
        int t0, n, lat0;
        load_expect();
        @(posedge clk); #1;
        frame_start = 1'b1;
        t0   = cyc;
        lat0 = nlatch;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        n = 0;
        while (!frame_done && n < 40000) begin
            @(posedge clk); #1;
            n++;
            frame_start = (n == pulse_at);
        end
        frame_start = 1'b0;
        check("frame_done_seen", 64'(frame_done), 64'd1);
        check("frame_cycles", 64'(cyc - t0), 64'(ROWS * PER_ROW + 1));
        check("busy_at_done", 64'(busy), 64'd0);
        check("latches_per_frame", 64'(nlatch - lat0), 64'(ROWS * PLANES));
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        check("frame_done_one_cycle", 64'(frame_done), 64'd0);
    endtask

    initial begin
        int n, act, bad10;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        clear_tables();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(out_vec()), 64'd0);
        check("reset_controls", 64'(ctl_vec()), 64'(13'b0000000_0_1_0_0_00));
        @(negedge clk) rst_n = 1'b1;

        // Reset in the middle of shifting column 20
        random_tables(ROWS);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        n = 0;
        while (col_now != 7'd20 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_col20", 64'(col_now), 64'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'(out_vec()), 64'd0);
        check("midreset_controls", 64'(ctl_vec()), 64'(13'b0000000_0_1_0_0_00));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        act = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || led_sclk || led_lat || !led_oe_n || row_now != 0 || col_now != 0) act++;
        end
        check("quiet_after_reset", 64'(act), 64'd0);

        // Frame 1: directed decoder pattern plus random fill, frame_start pulsed while busy
        clear_tables();
        random_tables(ROWS - 1);
        for (int r = 0; r < 128; r++) begin
            j1[r][10] = 1'b1;
            j2[r][10] = 1'b1;
            j3[r][10] = 1'b1;
        end
        j1[53][0] = 1'b0; j2[53][0] = 1'b0; j3[53][0] = 1'b1;
        j1[53][1] = 1'b0; j2[53][1] = 1'b1; j3[53][1] = 1'b0;
        j1[53][2] = 1'b1; j2[53][2] = 1'b0; j3[53][2] = 1'b0;
        j1[53][3] = 1'b0; j2[53][3] = 1'b1; j3[53][3] = 1'b0;
        j1[53][4] = 1'b0; j2[53][4] = 1'b0; j3[53][4] = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_frame($urandom_range(500, 30000));
        check("row53_plane0_cols0to4", 64'(captured[53][0][4:0]), 64'(5'b11111));
        check("row53_plane3_cols0to4", 64'(captured[53][3][4:0]), 64'(5'b01110));
        check("row53_plane1_cols0to4", 64'(captured[53][1][4:0]), 64'(5'b10101));
        bad10 = 0;
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < PLANES; p++)
                if (captured[r][p][10] !== 1'b1) bad10++;
        check("col10_all_judges_planes", 64'(bad10), 64'd0);

        // Frame 2: fully random decoder, started after frame_done
        repeat ($urandom_range(3, 20)) @(posedge clk);
        random_tables(ROWS);
        run_frame(0);

        check("protocol_violations", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
